// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 front end.
// Contents: datapath width, the canonical NOP (addi x0,x0,0), the base
// opcode constants the decoder switches on, and the fetch FSM state type.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // S_REQ : nothing outstanding
  // S_WAIT: one request outstanding, its response is wanted
  // S_DROP: one request outstanding, its response must be discarded
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a single-entry skid buffer.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush_i           redirect: invalidate IF/ID and empty the skid
//   stall_i           decode cannot consume IF/ID this cycle
//   rsp_load_i        load the fresh response straight into IF/ID
//   skid_wr_i         park the fresh response in the skid entry
//   rsp_instr_i/pc_i  fresh instruction word and its fetch address
//   valid_o/instr_o/pc_o/pc_plus4_o  registered IF/ID contents
//   skid_full_o       skid entry occupied
module if_id_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            rsp_load_i,
  input  logic            skid_wr_i,
  input  logic [31:0]     rsp_instr_i,
  input  logic [XLEN-1:0] rsp_pc_i,
  output logic            valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            skid_full_o
);
  import riscv_pkg::*;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic            skid_full_q, skid_full_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            can_accept_s;

  assign can_accept_s = !valid_q || !stall_i;

  // Next-state selection for IF/ID and skid, flush has top priority.
  always_comb begin
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    pc_plus4_d   = pc_plus4_q;
    skid_full_d  = skid_full_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush_i) begin
      valid_d     = 1'b0;
      instr_d     = NOP_INSTR;
      skid_full_d = 1'b0;
    end else if (skid_full_q && can_accept_s) begin
      // Skid drains first; the fetch side never delivers a response while
      // the skid is full, so there is no second source to arbitrate.
      valid_d     = 1'b1;
      instr_d     = skid_instr_q;
      pc_d        = skid_pc_q;
      pc_plus4_d  = skid_pc_q + PC_STEP;
      skid_full_d = 1'b0;
    end else if (rsp_load_i) begin
      valid_d    = 1'b1;
      instr_d    = rsp_instr_i;
      pc_d       = rsp_pc_i;
      pc_plus4_d = rsp_pc_i + PC_STEP;
    end else if (skid_wr_i) begin
      skid_full_d  = 1'b1;
      skid_instr_d = rsp_instr_i;
      skid_pc_d    = rsp_pc_i;
    end else if (valid_q && !stall_i) begin
      // Decode consumed the instruction and nothing replaces it: bubble.
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else begin
      valid_d = valid_q;
    end
  end

  // IF/ID and skid state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc_q         <= '0;
      pc_plus4_q   <= PC_STEP;
      skid_full_q  <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      pc_plus4_q   <= pc_plus4_d;
      skid_full_q  <= skid_full_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign valid_o     = valid_q;
  assign instr_o     = instr_q;
  assign pc_o        = pc_q;
  assign pc_plus4_o  = pc_plus4_q;
  assign skid_full_o = skid_full_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, request FSM and the IF/ID register.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   imem_req_valid/ready/addr       request channel to instruction memory
//   imem_rsp_valid/data             in-order response channel
//   stall_d                         decode cannot consume IF/ID
//   redirect_valid/redirect_pc      taken branch/jump from execute
//   id_valid/id_instr/id_pc/id_pc_plus4/id_op  IF/ID outputs to decode
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            stall_d,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [6:0]      id_op
);
  import riscv_pkg::*;

  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(32'd4);
  localparam logic [XLEN-1:0] ALN_MASK = XLEN'(32'd3);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  // Address of the request currently in flight; pc_q has already moved on.
  logic [XLEN-1:0] req_addr_q, req_addr_d;

  logic can_accept_s;
  logic rsp_live_s;
  logic req_fire_s;
  logic rsp_load_s;
  logic skid_wr_s;
  logic skid_full_s;

  assign can_accept_s  = !id_valid || !stall_d;
  assign rsp_live_s    = (state_q == S_WAIT) && imem_rsp_valid;
  assign req_fire_s    = imem_req_valid && imem_req_ready;
  assign imem_req_addr = pc_q;

  // State, PC and outstanding-address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // Next-state logic: redirect overrides everything, and a response seen in
  // S_REQ (protocol error) or S_DROP never reaches IF/ID.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~ALN_MASK;
      case (state_q)
        S_REQ:   state_d = S_REQ;
        S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        S_DROP:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      if (req_fire_s) begin
        pc_d       = pc_q + PC_STEP;
        req_addr_d = pc_q;
      end else begin
        pc_d = pc_q;
      end
      case (state_q)
        S_REQ:   state_d = req_fire_s ? S_WAIT : S_REQ;
        S_WAIT:  state_d = (!imem_rsp_valid || req_fire_s) ? S_WAIT : S_REQ;
        S_DROP:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end
  end

  // Request valid and IF/ID steering. rst_n gates the request so nothing is
  // offered while reset is held; the first request appears as soon as it lifts.
  always_comb begin
    imem_req_valid = 1'b0;
    rsp_load_s     = 1'b0;
    skid_wr_s      = 1'b0;
    if (rst_n && !redirect_valid) begin
      case (state_q)
        S_REQ:   imem_req_valid = !skid_full_s;
        S_WAIT:  imem_req_valid = !skid_full_s && imem_rsp_valid && can_accept_s;
        S_DROP:  imem_req_valid = 1'b0;
        default: imem_req_valid = 1'b0;
      endcase
      rsp_load_s = rsp_live_s && can_accept_s;
      skid_wr_s  = rsp_live_s && !can_accept_s;
    end else begin
      imem_req_valid = 1'b0;
    end
  end

  if_id_reg #(
    .XLEN(XLEN)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect_valid),
    .stall_i    (stall_d),
    .rsp_load_i (rsp_load_s),
    .skid_wr_i  (skid_wr_s),
    .rsp_instr_i(imem_rsp_data),
    .rsp_pc_i   (req_addr_q),
    .valid_o    (id_valid),
    .instr_o    (id_instr),
    .pc_o       (id_pc),
    .pc_plus4_o (id_pc_plus4),
    .skid_full_o(skid_full_s)
  );

  assign id_op = id_instr[6:0];

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register directly upstream of the main decoder.
- Holds the PC and issues word requests to instruction memory over a valid/ready request channel with a fixed-order response channel.
- Registers fetched instructions and presents id_op = id_instr[6:0] to the decoder.
- Handles decode stalls with a 1-entry skid buffer and handles branch/jump redirects (PCSrc path) by flushing to NOP.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  instruction data valid; at most one response per accepted request, in order.
- imem_rsp_data  in  32  instruction word.
- stall_d  in  1  decode stage cannot consume IF/ID this cycle.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_pc  in  XLEN  redirect target; bits [1:0] forced to 0.
- id_valid  out  1  IF/ID holds a real instruction.
- id_instr  out  32  instruction; NOP (32'h0000_0013) when invalid.
- id_pc  out  XLEN  PC of id_instr.
- id_pc_plus4  out  XLEN  id_pc+4.
- id_op  out  7  id_instr[6:0], feeds decoder Op.

Behaviour:
- Reset (async, rst_n=0): pc_q=RESET_PC, state=S_REQ, skid empty, id_valid=0, id_instr=NOP, id_pc=0, id_pc_plus4=4, imem_req_valid=0.
- First request is issued in the first cycle after rst_n deasserts.
- States:
  - S_REQ: no request outstanding.
  - S_WAIT: one request outstanding.
  - S_DROP: one outstanding request whose response must be discarded.
- can_accept = !id_valid || !stall_d.
- imem_req_valid = !redirect_valid && skid_empty && (S_REQ || (S_WAIT && imem_rsp_valid && can_accept)).
- imem_req_addr = pc_q.
- Request accepted when valid && ready: pc_q <= pc_q+4, next state S_WAIT.
- While waiting on ready=0, the address stays stable.
- Responses:
  - Response in S_WAIT, no redirect: if can_accept, load IF/ID (id_valid=1, id_pc = address of that request); else write to skid.
  - Next state after a response is S_WAIT if a new request was accepted that cycle, else S_REQ.
  - Track the outstanding request's address in a register; pc_q alone is insufficient.
- Throughput: with ready=1 and a 1-cycle response, one instruction per cycle.
- Skid:
  - Full skid blocks new requests.
  - Skid drains into IF/ID when can_accept.
  - Skid and a fresh response never coincide, by construction.
- IF/ID when nothing is loaded: if id_valid && !stall_d, then id_valid=0 and id_instr=NOP. With stall_d=1, all id_* outputs hold.
- Redirect (highest priority, beats stall_d):
  - Next cycle: id_valid=0, id_instr=NOP, skid cleared, pc_q=redirect_pc&~3.
  - No request is issued that cycle.
  - Any response in that cycle is discarded.
  - S_WAIT without a response goes to S_DROP; S_WAIT with a response goes to S_REQ.
  - S_DROP stays until its response arrives, then goes to S_REQ.
- A response arriving in S_REQ is a protocol error: ignore it and hold state.
- pc_q wraps modulo 2^XLEN.
- Reset asserted mid-operation discards all in-flight state immediately.

Decomposition:
- Shared package riscv_pkg:
  - XLEN and NOP_INSTR.
  - Opcode constants (OP_R 7'b0110011, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM, OP_JALR, OP_JAL).
  - Fetch state enum {S_REQ, S_WAIT, S_DROP}.
- Sub-module if_id_reg:
  - IF/ID register plus skid entry.
  - Load, hold and flush controls.
  - Keeps fetch_stage as the FSM and PC only.

Test Plan:
- Release reset, ready=1, response 1 cycle after each request with data = addr|0x13 → requests at 0x0, 0x4, 0x8 on consecutive cycles; id_pc 0x0, 0x4, 0x8 back-to-back; id_valid stays 1.
- stall_d=1 for 3 cycles while IF/ID holds 0x00500093 @0x4 → id_* stable; response for 0x8 goes to skid; imem_req_valid=0. Release → id_pc=0x8 next cycle and request 0xC issued.
- redirect_valid with redirect_pc=0x102 while 0x10 is outstanding → next cycle id_valid=0, id_instr=0x00000013; the late 0x10 response is dropped; next request address is 0x100.
- redirect_valid and stall_d both high with IF/ID full → flush wins: id_valid=0 next cycle.
- imem_req_ready=0 for 4 cycles at pc 0x8 → imem_req_valid=1 and addr=0x8 held throughout; a single request is accepted when ready rises.
- rst_n low for one cycle during S_WAIT → outputs at reset values immediately; the stale response after release is ignored; the first request is at RESET_PC.
